rr_arbiter8: RTL and testbench

//  Round-robin arbiter sharing one 8-way resource between 8 requesters.

---
 rtl/rr_arbiter8_pkg.sv | 36 +++
 rtl/rr_arbiter8_prienc.sv | 20 ++
 rtl/rr_arbiter8.sv | 109 ++++++++++
 tb/tb_rr_arbiter8.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter.
// The rotation helper lines the scan order up so the highest bit is the first candidate.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // rot[7-k] = req[(last_id + 1 + k) mod 8]; the 3-bit index wraps naturally.
    function automatic logic [N_REQ-1:0] rotate_req(
        input logic [N_REQ-1:0] req,
        input logic [ID_W-1:0]  last_id
    );
        logic [N_REQ-1:0] rot;
        logic [ID_W-1:0]  idx;
        rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = last_id + ID_W'(k + 1);
            rot[N_REQ-1-k] = req[idx];
        end
        return rot;
    endfunction

    // Undo the rotation: (last_id + 8 - enc) mod 8.
    function automatic logic [ID_W-1:0] unrotate_id(
        input logic [ID_W-1:0] last_id,
        input logic [ID_W-1:0] enc
    );
        return last_id - enc;
    endfunction

endpackage

// File: rtl/rr_arbiter8_prienc.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit.
// valid is low (and enc is 0) when no input bit is set.
module priority_encoder8to3 (
    input  logic [7:0] in_vec,
    output logic [2:0] enc,
    output logic       valid
);

    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
                enc = 3'(i);
            end
        end
    end

    assign valid = |in_vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared resource and 8 requesters.
// Grants are held until done, request drop, or the MAX_HOLD limit, with a one-cycle bubble between owners.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    state_e           state_q,    state_d;
    logic [N_REQ-1:0] grant_q,    grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q,  last_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  enc;
    logic             enc_valid;
    logic [ID_W-1:0]  winner;
    logic             owner_req;
    logic             at_limit;
    logic             release_now;

    assign rot = rotate_req(req, last_id_q);

    priority_encoder8to3 u_prienc (
        .in_vec (rot),
        .enc    (enc),
        .valid  (enc_valid)
    );

    assign winner      = unrotate_id(last_id_q, enc);
    assign owner_req   = req[grant_id_q];
    assign at_limit    = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign release_now = done | ~owner_req | at_limit;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d    = '0;
                hold_cnt_d = '0;
                if (enc_valid) begin
                    state_d    = ST_BUSY;
                    grant_d    = N_REQ'(1) << winner;
                    grant_id_d = winner;
                    last_id_d  = winner;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    // A done coinciding with the limit is an ordinary release.
                    timeout_d  = at_limit & ~done & owner_req;
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = (state_q == ST_BUSY);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a behavioural owner/pointer model predicts each cycle,
// a separate monitor compares the DUT outputs one cycle later.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    // Reference model: owner index (-1 = nobody), last winner, hold length.
    int m_owner, m_last, m_id, m_hold;
    bit m_timeout;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner   = -1;
        m_last    = 7;
        m_id      = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic d);
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            int w;
            w = rr_pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_id    = w;
                m_hold  = 1;
            end
        end else begin
            if (d || !r[m_owner] || m_hold == MAX_HOLD) begin
                m_timeout = (m_hold == MAX_HOLD) && !d && r[m_owner];
                m_owner   = -1;
                m_hold    = 0;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.grant   = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
        e.id      = 3'(m_id);
        e.valid   = (m_owner >= 0);
        e.timeout = m_timeout;
        return e;
    endfunction

    task automatic drive_step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        model_step(r, d);
        exp_q.push_back(model_out());
    endtask

    task automatic cycle(input logic [7:0] r, input logic d);
        @(negedge clk);
        drive_step(r, d);
    endtask

    task automatic sample_after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic cycle_chk(input logic [7:0] r, input logic d, input logic [2:0] exp_id);
        cycle(r, d);
        sample_after_edge();
        check("directed_grant_id", 32'(grant_id), 32'(exp_id));
        check("directed_grant_valid", 32'(grant_valid), 32'd1);
    endtask

    // Asynchronous reset a few ns after an edge, checked before the next edge.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_id", 32'(grant_id), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_step(8'h00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_grant", 32'(grant), 32'(e.grant));
                check("sb_grant_id", 32'(grant_id), 32'(e.id));
                check("sb_grant_valid", 32'(grant_valid), 32'(e.valid));
                check("sb_timeout", 32'(timeout), 32'(e.timeout));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int n_to;
        int held;
        logic [7:0] r;
        logic d;

        model_reset();
        #3;
        check("por_grant", 32'(grant), 32'd0);
        check("por_valid", 32'(grant_valid), 32'd0);
        check("por_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_step(8'h00, 1'b0);

        // Single requester straight after reset.
        cycle_chk(8'h10, 1'b0, 3'd4);
        check("t1_grant", 32'(grant), 32'h10);
        cycle(8'h10, 1'b1);

        // Everyone requesting, done each grant: 0..7 then wrap to 0.
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            cycle_chk(8'hFF, 1'b0, 3'(i % 8));
            cycle(8'hFF, 1'b1);
            sample_after_edge();
            check("t2_bubble", 32'(grant), 32'd0);
        end

        // Wrap from last_id=6 to requester 0, then back to 6.
        apply_reset();
        cycle_chk(8'h40, 1'b0, 3'd6);
        cycle(8'h40, 1'b1);
        cycle_chk(8'h41, 1'b0, 3'd0);
        cycle(8'h41, 1'b1);
        cycle_chk(8'h41, 1'b0, 3'd6);
        cycle(8'h00, 1'b0);

        // Hold limit with a lone requester.
        n_to = 0;
        held = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(8'h04, 1'b0);
            sample_after_edge();
            if (timeout) n_to++;
            if (grant_valid && n_to == 0) held++;
        end
        check("t4_timeout_pulses", 32'(n_to), 32'd1);
        check("t4_held_cycles", 32'(held), 32'(MAX_HOLD));
        check("t4_regrant_id", 32'(grant_id), 32'd2);
        cycle(8'h00, 1'b0);

        // Owner 5 drops its request while requester 1 waits.
        cycle_chk(8'h20, 1'b0, 3'd5);
        cycle(8'h22, 1'b0);
        cycle(8'h02, 1'b0);
        sample_after_edge();
        check("t5_release_valid", 32'(grant_valid), 32'd0);
        check("t5_release_timeout", 32'(timeout), 32'd0);
        cycle_chk(8'h02, 1'b0, 3'd1);
        cycle(8'h00, 1'b0);

        // Reset while requester 3 owns the grant; pointer returns to 7.
        cycle(8'h00, 1'b0);
        cycle(8'h08, 1'b0);
        apply_reset();
        cycle_chk(8'h88, 1'b0, 3'd3);
        cycle(8'h00, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: r = 8'(1) << $urandom_range(0, 7);
                1: r = 8'($urandom) & 8'($urandom);
                default: r = 8'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) r = 8'h00;
            d = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0 && m_owner >= 0) r[m_owner] = 1'b1;
            cycle(r, d);
            if ($urandom_range(0, 399) == 0) apply_reset();
        end

        cycle(8'h00, 1'b1);
        sample_after_edge();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
